// File: rtl/bcd2bin_seq_pkg.sv
// Shared types and constants for the iterative BCD-to-binary converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_CORR = 4'd3;

  typedef enum logic [1:0] {IDLE, CALC, DONE} bcd_conv_state_t;

  // Smallest binary width able to hold every value of a digits-wide decimal word.
  function automatic int bin_width(input int digits);
    longint unsigned p;
    int              w;
    p = 64'd1;
    for (int i = 0; i < digits; i++) p = p * 64'd10;
    w = 0;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < p) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Valid/ready request (packed BCD) and response (binary + error) bundle.
interface bcd2bin_seq_if
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 3,
  parameter int N        = 10
);
  logic                            in_valid;
  logic                            in_ready;
  logic [BCD_DIGIT_W*N_DIGITS-1:0] in_bcd;
  logic                            out_valid;
  logic                            out_ready;
  logic [N-1:0]                    out_bin;
  logic                            out_err;

  modport master (
    output in_valid, in_bcd, out_ready,
    input  in_ready, out_valid, out_bin, out_err
  );

  modport slave (
    input  in_valid, in_bcd, out_ready,
    output in_ready, out_valid, out_bin, out_err
  );
endinterface

// File: rtl/bcd2bin_seq_digit_sub3.sv
// One-digit correction for reverse double-dabble: digits of 8 or more lose 3.
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_d,
  output logic [BCD_DIGIT_W-1:0] o_d
);
  assign o_d = (i_d >= 4'd8) ? i_d - BCD_CORR : i_d;
endmodule

// File: rtl/bcd2bin_seq.sv
// Iterative BCD-to-binary converter: one right shift plus per-digit correction
// per cycle, N cycles per word, valid/ready on both sides, illegal-digit flag.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 3,
  parameter int N        = 10
) (
  input logic          clk,
  input logic          rst,
  bcd2bin_seq_if.slave bus
);
  localparam int BCD_W = BCD_DIGIT_W * N_DIGITS;
  localparam int CNT_W = $clog2(N) + 1;

  if (N_DIGITS < 1 || N < bin_width(N_DIGITS)) begin : g_param_check
    $error("bcd2bin_seq: need N_DIGITS >= 1 and 2**N >= 10**N_DIGITS");
  end

  bcd_conv_state_t    r_state, w_next_state;
  logic [BCD_W-1:0]   r_bcd;
  logic [BCD_W-1:0]   w_bcd_fix;
  logic [N-1:0]       r_bin;
  logic               r_err;
  logic               w_in_err;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W+N-1:0] w_shifted;

  // The BCD digits drain LSB-first into the top of the binary register.
  assign w_shifted = {r_bcd, r_bin} >> 1;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    bcd_digit_sub3 u_sub3 (
      .i_d(w_shifted[N + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_d(w_bcd_fix[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    w_in_err = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bus.in_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) w_in_err = 1'b1;
    end
  end

  always_comb begin
    // NOTE: default assigned before the case so no path leaves it unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_next_state = CALC;
      CALC:    if (r_cnt == CNT_W'(N - 1)) w_next_state = DONE;
      DONE:    if (bus.out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_bcd   <= '0;
      r_bin   <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_bcd <= bus.in_bcd;
            r_bin <= '0;
            r_err <= w_in_err;
            r_cnt <= '0;
          end
        end
        CALC: begin
          r_bcd <= w_bcd_fix;
          r_bin <= w_shifted[N-1:0];
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_bin   = r_err ? '0 : r_bin;
  assign bus.out_err   = r_err;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: vector table, handshake corner cases,
// random back-to-back traffic against a decimal-arithmetic model, 1-digit sweep.
module tb_bcd2bin_seq;
  import bcd_pkg::*;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bcd2bin_seq_if #(.N_DIGITS(3), .N(10)) bus  ();
  bcd2bin_seq_if #(.N_DIGITS(1), .N(4))  bus1 ();

  bcd2bin_seq #(.N_DIGITS(3), .N(10)) dut  (.clk(clk), .rst(rst), .bus(bus));
  bcd2bin_seq #(.N_DIGITS(1), .N(4))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [11:0] bcd;
    logic [9:0]  bin;
    logic        err;
  } vec_t;

  vec_t        vecs[10];
  int          checks   = 0;
  int          failures = 0;
  int          lat;
  int          hits;
  int          acc, res, cyc, last_acc;
  int          exp_val;
  bit          exp_err;
  int          v;
  logic [11:0] w;
  int          exp_q[$];
  bit          err_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: weight each digit by its power of ten; any digit above 9 forces 0 + error.
  function automatic void ref_conv(input logic [11:0] bcd, output int val, output bit err);
    int scale;
    int d;
    scale = 1;
    val   = 0;
    err   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = int'(bcd[i*4 +: 4]);
      if (d > 9) err = 1'b1;
      val   = val + d * scale;
      scale = scale * 10;
    end
    if (err) val = 0;
  endfunction

  task automatic convert(input string name, input logic [11:0] bcd,
                         input logic [9:0] exp_bin, input logic exp_e);
    int l;
    @(negedge clk);
    check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_bcd   = bcd;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_bcd   = 12'hFFF;
    l = 0;
    while (!bus.out_valid && l < 50) begin
      @(negedge clk);
      l++;
    end
    check({name, "_latency"}, 32'(l), 32'd10);
    check({name, "_bin"}, 32'(bus.out_bin), 32'(exp_bin));
    check({name, "_err"}, 32'(bus.out_err), 32'(exp_e));
    check({name, "_no_ready"}, 32'(bus.in_ready), 32'd0);
    if (!exp_e) check({name, "_residue"}, 32'(dut.r_bcd), 32'd0);
    @(negedge clk);
    check({name, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{12'h255, 10'd255, 1'b0};
    vecs[1] = '{12'h999, 10'h3E7, 1'b0};
    vecs[2] = '{12'h000, 10'd0,   1'b0};
    vecs[3] = '{12'h1A3, 10'd0,   1'b1};
    vecs[4] = '{12'h042, 10'd42,  1'b0};
    vecs[5] = '{12'h990, 10'd990, 1'b0};
    vecs[6] = '{12'h09A, 10'd0,   1'b1};
    vecs[7] = '{12'hF00, 10'd0,   1'b1};
    vecs[8] = '{12'h100, 10'd100, 1'b0};
    vecs[9] = '{12'h512, 10'd512, 1'b0};

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_bcd     = '0;
    bus.out_ready  = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.in_bcd    = '0;
    bus1.out_ready = 1'b1;

    // Reset and idle
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_bin",   32'(bus.out_bin),   32'd0);
    check("rst_out_err",   32'(bus.out_err),   32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      convert($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].bin, vecs[i].err);
    end

    // Backpressure: result held for 5 cycles, released on first out_ready
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bcd   = 12'h128;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", 32'(lat), 32'd10);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", 32'(bus.out_valid), 32'd1);
      check("bp_bin_held",   32'(bus.out_bin),   32'd128);
      check("bp_no_ready",   32'(bus.in_ready),  32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    check("bp_valid_last", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    check("bp_valid_drop", 32'(bus.out_valid), 32'd0);
    check("bp_ready_back", 32'(bus.in_ready),  32'd1);

    // Reset during CALC discards the conversion
    hits = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bcd   = 12'h500;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.out_valid) hits++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) hits++;
    end
    check("midrst_no_valid", 32'(hits), 32'd0);
    convert("after_rst", 12'h007, 10'd7, 1'b0);

    // Back-to-back random legal words with in_valid held high
    acc      = 0;
    res      = 0;
    cyc      = 0;
    last_acc = -1;
    while (res < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected", 32'd1, 32'd0);
        end else begin
          exp_val = exp_q.pop_front();
          exp_err = err_q.pop_front();
          check("rand_bin",     32'(bus.out_bin), 32'(exp_val));
          check("rand_err",     32'(bus.out_err), 32'(exp_err));
          check("rand_residue", 32'(dut.r_bcd),   32'd0);
        end
        res++;
      end
      if (bus.in_ready) begin
        if (acc < 1000) begin
          v = int'($urandom_range(999, 0));
          w = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
          ref_conv(w, exp_val, exp_err);
          exp_q.push_back(exp_val);
          err_q.push_back(exp_err);
          bus.in_valid = 1'b1;
          bus.in_bcd   = w;
          if (last_acc >= 0) check("rand_ii", 32'(cyc - last_acc), 32'd12);
          last_acc = cyc;
          acc++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end else begin
        bus.in_bcd = 12'($urandom);
      end
    end
    bus.in_valid = 1'b0;
    check("rand_count", 32'(res), 32'd1000);

    // Single-digit instance: full nibble sweep, N = 4 cycles
    for (int d = 0; d < 16; d++) begin
      @(negedge clk);
      bus1.in_valid = 1'b1;
      bus1.in_bcd   = 4'(d);
      @(negedge clk);
      bus1.in_valid = 1'b0;
      lat = 0;
      while (!bus1.out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check("d1_latency", 32'(lat), 32'd4);
      check("d1_bin", 32'(bus1.out_bin), (d > 9) ? 32'd0 : 32'(d));
      check("d1_err", 32'(bus1.out_err), (d > 9) ? 32'd1 : 32'd0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
Iterative BCD-to-binary converter; inverse of the combinational binary-to-BCD block. Uses reverse double-dabble: shift right one bit per cycle, then subtract 3 from every BCD digit that is >= 8. Has valid/ready handshakes on both sides, so it sits between a decimal-entry or display-side datapath and binary arithmetic logic. Also flags illegal BCD digits.

Parameters:
N_DIGITS, 3, number of packed BCD digits on the input (>= 1).
N, 10, output binary width; must satisfy 2^N >= 10^N_DIGITS (elaboration-time assertion otherwise).

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  in_bcd is valid.
in_ready  out  1  block can accept a word (high only in IDLE).
in_bcd  in  4*N_DIGITS  packed BCD; digit 0 is in bits [3:0].
out_valid  out  1  out_bin and out_err are valid.
out_ready  in  1  downstream accepts the result.
out_bin  out  N  binary result.
out_err  out  1  at least one input digit was > 9.

Behaviour:
- Reset (rst=1 at an edge): state = IDLE; out_valid=0, out_bin=0, out_err=0, internal counter=0, bcd/bin working registers=0; in_ready=1 after reset. Reset overrides everything else.
- Reset mid-operation: an in-flight conversion or a held result is discarded with no output.
- States:
  - IDLE: in_ready=1. On in_valid & in_ready:
    - load bcd_reg <= in_bcd and bin_reg <= 0;
    - set err_reg <= OR over digits of (digit > 9);
    - clear cnt <= 0; go to CALC.
  - CALC: in_ready=0. On every edge:
    - shift the concatenation {bcd_reg, bin_reg} right by 1;
    - then, for each digit of the shifted bcd_reg, if digit >= 8, subtract 3 (4-bit, no borrow between digits);
    - cnt++. After the N-th CALC edge (cnt == N-1), go to DONE.
  - DONE: out_valid=1.
    - out_bin = bin_reg, or 0 if err_reg=1; out_err = err_reg.
    - Outputs are stable while out_valid & !out_ready.
    - On out_valid & out_ready, go to IDLE and set out_valid=0.
- Latency: accept edge at cycle k; out_valid rises immediately after edge k+N. Minimum initiation interval is N+2 cycles (one DONE cycle, then IDLE for the next accept).
- in_ready is never high in the same cycle as out_valid; there is no overlap.
- Counter width: $clog2(N)+1 bits; it never wraps within a conversion.
- Width rule: bcd_reg is 4*N_DIGITS bits and bin_reg is N bits. After N shifts of a legal input, bcd_reg must be all-zero; the bench checks this internally.
- Illegal digits (A–F): the conversion still runs the full N cycles (constant timing). The result is forced to 0 and out_err=1.
- in_bcd is sampled only on the accept edge; later changes are ignored.

Decomposition:
- Shared package bcd_pkg holds:
  - localparam BCD_DIGIT_W = 4, localparam BCD_CORR = 4'd3;
  - function bin_width(digits), which returns ceil(log2(10^digits));
  - typedef enum logic [1:0] {IDLE, CALC, DONE} bcd_conv_state_t.
- One natural sub-module: bcd_digit_sub3, a combinational correction for one digit (if d >= 8 then d-3). It is instantiated N_DIGITS times via generate.
- The top level holds the FSM, counter, shift registers and handshakes.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> in_ready=1, out_valid=0, out_bin=0, out_err=0.
- Basic conversions (N_DIGITS=3, N=10):
  - in_bcd=12'h255 -> out_bin=10'd255 (0x0FF), out_err=0, out_valid exactly 10 cycles after the accept edge;
  - 12'h999 -> 10'h3E7;
  - 12'h000 -> 0.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises -> out_bin is held at 12'h128→10'd128 and in_ready stays 0; the transfer completes on the first out_ready=1 cycle, and in_ready=1 on the next cycle.
- Illegal digit: in_bcd=12'h1A3 -> after 10 cycles out_err=1, out_bin=0. A following legal 12'h042 -> out_bin=42, out_err=0.
- Reset mid-CALC: accept 12'h500, assert rst 4 cycles later -> no out_valid pulse. Then 12'h007 -> out_bin=7.
- Back-to-back plus random: with in_valid held high and out_ready=1, drive 1000 random legal 3-digit words -> each result equals the decimal value, with initiation interval exactly 12 cycles. Also repeat with N_DIGITS=1, N=4 over inputs 0..9.
